// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: bubble word, reset/memory defaults, state encoding.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR     = 32'hFC00_0000;
    localparam logic [31:0] RESET_PC_DEF  = 32'd0;
    localparam logic [31:0] MEM_BYTES_DEF = 32'd1024;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_t;

    // A fetch address is bad when misaligned or past the last legal word.
    function automatic logic pc_is_bad(input logic [31:0] pc, input logic [31:0] mem_bytes);
        return (pc[1:0] != 2'b00) || (pc > (mem_bytes - 32'd4));
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: hold beats flush, flush loads a bubble.
module if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] BUBBLE = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] d_instr,
    input  logic [31:0] d_pc4,
    output logic [31:0] q_instr,
    output logic [31:0] q_pc4,
    output logic        q_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    // Capture, hold or bubble the stage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr <= BUBBLE;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else if (hold) begin
            r_instr <= r_instr;
        end else if (flush) begin
            r_instr <= BUBBLE;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else begin
            r_instr <= d_instr;
            r_pc4   <= d_pc4;
            r_valid <= 1'b1;
        end
    end

    assign q_instr = r_instr;
    assign q_pc4   = r_pc4;
    assign q_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: program counter, next-pc selection, bad-address fault and IF/ID register.
//
// state    | meaning
// ST_RUN   | fetching; stall > redirect > bad_pc > advance
// ST_FAULT | bad fetch address seen; everything frozen until rst
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] MEM_BYTES = MEM_BYTES_DEF,
    parameter logic [31:0] NOP_WORD  = NOP_INSTR,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      pc,
    input  logic [31:0]      command,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_target,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic             fault,
    output logic [CNT_W-1:0] fetch_count
);

    fetch_state_t     r_state;
    logic [31:0]      r_pc;
    logic             r_fault;
    logic [CNT_W-1:0] r_count;

    logic [31:0] w_pc4;
    logic        w_bad;
    logic        w_hold;
    logic        w_flush;

    assign w_pc4   = r_pc + 32'd4;
    assign w_bad   = pc_is_bad(r_pc, MEM_BYTES);
    // FAULT freezes the stage register exactly like a stall.
    assign w_hold  = (r_state == ST_FAULT) || stall;
    assign w_flush = redirect || w_bad;

    // Fetch state machine with pc, fault flag and valid-fetch counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (stall) begin
                        r_pc <= r_pc;
                    end else if (redirect) begin
                        // Accepted even from a bad pc: the current fetch is discarded.
                        r_pc <= redirect_target;
                    end else if (w_bad) begin
                        r_state <= ST_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_pc    <= w_pc4;
                        r_count <= r_count + 1'b1;
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_FAULT;
                    r_fault <= 1'b1;
                end
            endcase
        end
    end

    if_id_reg #(
        .BUBBLE (NOP_WORD)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .hold    (w_hold),
        .flush   (w_flush),
        .d_instr (command),
        .d_pc4   (w_pc4),
        .q_instr (if_id_instr),
        .q_pc4   (if_id_pc4),
        .q_valid (if_id_valid)
    );

    assign pc          = r_pc;
    assign fault       = r_fault;
    assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, then random stimulus against a rule-level model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] command;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        fault;
    logic [15:0] fetch_count;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (32'd0),
        .MEM_BYTES (32'd1024),
        .NOP_WORD  (NOP),
        .CNT_W     (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .command         (command),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .if_id_instr     (if_id_instr),
        .if_id_pc4       (if_id_pc4),
        .if_id_valid     (if_id_valid),
        .fault           (fault),
        .fetch_count     (fetch_count)
    );

    // Instruction memory: each word encodes its own byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2000_0000 | (a & 32'h0000_03FF);
    endfunction

    assign command = (pc < 32'd1024) ? mem_word(pc) : 32'hDEAD_BEEF;

    // Reference model, stepped once per clock from the behavioural rules.
    logic        m_fault;
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    logic [15:0] m_cnt;

    task automatic model_step(input logic r, input logic s, input logic rd, input logic [31:0] t);
        bit bad;
        bad = ((m_pc % 4) != 0) || ((longint'(m_pc) + 4) > 1024);
        if (r) begin
            m_fault = 0; m_pc = 0; m_instr = NOP; m_pc4 = 0; m_valid = 0; m_cnt = 0;
        end else if (m_fault) begin
            // frozen
        end else if (s) begin
            // hold everything
        end else if (rd) begin
            m_pc = t; m_instr = NOP; m_pc4 = 0; m_valid = 0;
        end else if (bad) begin
            m_fault = 1; m_instr = NOP; m_pc4 = 0; m_valid = 0;
        end else begin
            m_instr = mem_word(m_pc);
            m_pc    = m_pc + 4;
            m_pc4   = m_pc;
            m_valid = 1;
            m_cnt   = m_cnt + 16'd1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic [31:0] e_pc4, input logic e_valid, input logic e_fault,
                             input logic [15:0] e_cnt);
        check({tag, ".pc"},          pc,                  e_pc);
        check({tag, ".if_id_instr"}, if_id_instr,         e_instr);
        check({tag, ".if_id_pc4"},   if_id_pc4,           e_pc4);
        check({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
        check({tag, ".fault"},       {31'd0, fault},       {31'd0, e_fault});
        check({tag, ".fetch_count"}, {16'd0, fetch_count}, {16'd0, e_cnt});
    endtask

    // Drive one cycle of inputs, clock it, and sample 1 time unit after the edge.
    task automatic apply(input logic r, input logic s, input logic rd, input logic [31:0] t);
        rst = r; stall = s; redirect = rd; redirect_target = t;
        model_step(r, s, rd, t);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst, stall, redir;
        logic [31:0] tgt;
        logic [31:0] e_pc, e_instr, e_pc4;
        logic        e_valid, e_fault;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic rd, input logic [31:0] t,
                       input logic [31:0] p, input logic [31:0] i, input logic [31:0] p4,
                       input logic v, input logic f, input logic [15:0] c);
        vec_t x;
        x.rst = r; x.stall = s; x.redir = rd; x.tgt = t;
        x.e_pc = p; x.e_instr = i; x.e_pc4 = p4; x.e_valid = v; x.e_fault = f; x.e_cnt = c;
        vecs.push_back(x);
    endtask

    initial begin
        rst = 1; stall = 0; redirect = 0; redirect_target = 0;
        m_fault = 0; m_pc = 0; m_instr = NOP; m_pc4 = 0; m_valid = 0; m_cnt = 0;
        #2;

        //   rst st rd target      pc     instr             pc4   v f cnt
        add(1, 0, 0, 0,          0,    NOP,              0,    0,0,0);
        add(0, 0, 0, 0,          4,    mem_word(0),      4,    1,0,1);
        add(0, 0, 0, 0,          8,    mem_word(4),      8,    1,0,2);
        add(0, 0, 0, 0,          12,   mem_word(8),      12,   1,0,3);
        add(0, 0, 0, 0,          16,   mem_word(12),     16,   1,0,4);
        add(0, 1, 0, 0,          16,   mem_word(12),     16,   1,0,4);
        add(0, 1, 0, 0,          16,   mem_word(12),     16,   1,0,4);
        add(0, 0, 0, 0,          20,   mem_word(16),     20,   1,0,5);
        add(0, 0, 1, 56,         56,   NOP,              0,    0,0,5);
        add(0, 0, 1, 36,         36,   NOP,              0,    0,0,5);
        add(0, 0, 0, 0,          40,   mem_word(36),     40,   1,0,6);
        add(0, 1, 1, 0,          40,   mem_word(36),     40,   1,0,6);
        add(0, 0, 1, 0,          0,    NOP,              0,    0,0,6);
        add(0, 0, 0, 0,          4,    mem_word(0),      4,    1,0,7);
        add(0, 0, 1, 1024,       1024, NOP,              0,    0,0,7);
        add(0, 0, 0, 0,          1024, NOP,              0,    0,1,7);
        add(0, 1, 0, 0,          1024, NOP,              0,    0,1,7);
        add(0, 0, 1, 0,          1024, NOP,              0,    0,1,7);
        add(0, 1, 1, 0,          1024, NOP,              0,    0,1,7);
        add(1, 0, 0, 0,          0,    NOP,              0,    0,0,0);
        add(0, 0, 0, 0,          4,    mem_word(0),      4,    1,0,1);
        add(0, 0, 1, 1024,       1024, NOP,              0,    0,0,1);
        add(0, 0, 1, 6,          6,    NOP,              0,    0,0,1);
        add(0, 0, 0, 0,          6,    NOP,              0,    0,1,1);
        add(1, 1, 1, 8,          0,    NOP,              0,    0,0,0);
        add(0, 0, 1, 1020,       1020, NOP,              0,    0,0,0);
        add(0, 0, 0, 0,          1024, mem_word(1020),   1024, 1,0,1);
        add(0, 0, 0, 0,          1024, NOP,              0,    0,1,1);
        add(1, 0, 0, 0,          0,    NOP,              0,    0,0,0);

        foreach (vecs[k]) begin
            apply(vecs[k].rst, vecs[k].stall, vecs[k].redir, vecs[k].tgt);
            check_all($sformatf("vec%0d", k), vecs[k].e_pc, vecs[k].e_instr, vecs[k].e_pc4,
                      vecs[k].e_valid, vecs[k].e_fault, vecs[k].e_cnt);
        end

        for (int n = 0; n < 3000; n++) begin
            logic        r, s, rd;
            logic [31:0] t;
            int          sel;
            r   = ($urandom_range(0, 63) == 0);
            s   = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 4) == 0);
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       t = 32'($urandom_range(0, 255)) << 2;
            else if (sel == 7) t = 32'($urandom_range(0, 1023));
            else if (sel == 8) t = 32'd1024 + (32'($urandom_range(0, 15)) << 2);
            else               t = 32'hFFFF_FFFC;
            apply(r, s, rd, t);
            check_all($sformatf("rnd%0d", n), m_pc, m_instr, m_pc4, m_valid, m_fault, m_cnt);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
